// File: rtl/clk_phase_gen_pkg.sv
// Shared types and helpers for the multi-channel phase generator.
// Channel config record, reset defaults and the phase window function.
package clk_phase_gen_pkg;

  localparam int MAX_W = 16;

  typedef logic [MAX_W-1:0] pos_t;
  typedef logic [MAX_W:0]   per_t;

  typedef struct packed {
    pos_t rise;
    pos_t fall;
    logic inv;
  } ch_cfg_t;

  function automatic ch_cfg_t cfg_default(
    input int unsigned period
  );
    ch_cfg_t c;
    c.rise = '0;
    c.fall = MAX_W'(period / 2);
    c.inv  = 1'b0;
    return c;
  endfunction

  // A rise position beyond the period is never reached, so the
  // channel rests at its inversion level. A fall position beyond
  // the period simply leaves the channel high up to P-1.
  function automatic logic win_hi(
    input ch_cfg_t cfg,
    input pos_t    c,
    input per_t    p
  );
    logic hi;
    hi = 1'b0;
    if ({1'b0, cfg.rise} < p) begin
      if (cfg.rise < cfg.fall) begin
        hi = (c >= cfg.rise) && (c < cfg.fall);
      end else if (cfg.rise > cfg.fall) begin
        hi = (c >= cfg.rise) || (c < cfg.fall);
      end
    end
    return hi ^ cfg.inv;
  endfunction

endpackage

// File: rtl/clk_phase_gen_if.sv
// Configuration and phase-output bundle of the phase generator.
// Master drives the config writes; slave is the generator itself.
interface clk_phase_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4,
  parameter int SEL_W  = 2
);

  logic              run;
  logic              per_we;
  logic [CNT_W:0]    per_val;
  logic              ch_we;
  logic [SEL_W-1:0]  ch_sel;
  logic [CNT_W-1:0]  ch_rise;
  logic [CNT_W-1:0]  ch_fall;
  logic              ch_inv;
  logic [NUM_CH-1:0] ch_clk;
  logic [NUM_CH-1:0] ch_rise_pulse;
  logic [CNT_W-1:0]  phase_cnt;
  logic              period_start;
  logic              cfg_pending;
  logic              cfg_err;

  modport master (
    output run, per_we, per_val,
    output ch_we, ch_sel, ch_rise, ch_fall, ch_inv,
    input  ch_clk, ch_rise_pulse, phase_cnt,
    input  period_start, cfg_pending, cfg_err
  );

  modport slave (
    input  run, per_we, per_val,
    input  ch_we, ch_sel, ch_rise, ch_fall, ch_inv,
    output ch_clk, ch_rise_pulse, phase_cnt,
    output period_start, cfg_pending, cfg_err
  );

endinterface

// File: rtl/clk_phase_gen_phase_chan.sv
// One phase output channel: shadow/active config, output flop
// and rising-edge pulse, all evaluated on the next counter value.
module clk_phase_gen_phase_chan
  import clk_phase_gen_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int RESET_PERIOD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             apply_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] rise_i,
  input  logic [CNT_W-1:0] fall_i,
  input  logic             inv_i,
  input  logic [CNT_W-1:0] cnt_d_i,
  input  logic [CNT_W:0]   per_d_i,
  output logic             clk_o,
  output logic             pulse_o,
  output logic             pending_o
);

  localparam ch_cfg_t CFG_RST = cfg_default(RESET_PERIOD);

  ch_cfg_t act_q, act_d;
  ch_cfg_t sh_q,  sh_d;
  logic    clk_q, clk_d;
  logic    pulse_q, pulse_d;

  // Load active from shadow at the wrap, then take the new write.
  always_comb begin
    act_d   = act_q;
    sh_d    = sh_q;
    clk_d   = clk_q;
    pulse_d = pulse_q;
    if (en_i) begin
      if (apply_i) begin
        act_d = sh_q;
      end
      if (wr_i) begin
        sh_d = '{rise: MAX_W'(rise_i),
                 fall: MAX_W'(fall_i),
                 inv:  inv_i};
      end
      clk_d   = win_hi(act_d, MAX_W'(cnt_d_i),
                       (MAX_W+1)'(per_d_i));
      pulse_d = clk_d & ~clk_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q   <= CFG_RST;
      sh_q    <= CFG_RST;
      clk_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      sh_q    <= sh_d;
      clk_q   <= clk_d;
      pulse_q <= pulse_d;
    end
  end

  assign clk_o     = clk_q;
  assign pulse_o   = pulse_q;
  assign pending_o = (sh_q != act_q);

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel clock/phase-enable generator: phase counter,
// period shadowing, write validation and the apply strobe.
module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 4,
  parameter int RESET_PERIOD = 4,
  parameter int SEL_W        = 2
) (
  input logic           clock,
  input logic           reset,
  clk_phase_gen_if.slave bus
);

  localparam logic [CNT_W:0] P_RST =
    (CNT_W+1)'(RESET_PERIOD);
  localparam logic [CNT_W:0] P_MIN = (CNT_W+1)'(2);
  localparam logic [CNT_W:0] P_MAX =
    (CNT_W+1)'(2**CNT_W);
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   per_q, per_d;
  logic [CNT_W:0]   per_sh_q, per_sh_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             apply;
  logic             per_ok;
  logic             per_acc;
  logic [CNT_W:0]   chk_per;
  logic [31:0]      sel_ext;
  logic             sel_ok;
  logic             pos_ok;
  logic             ch_acc;

  logic [NUM_CH-1:0] ch_clk;
  logic [NUM_CH-1:0] ch_pulse;
  logic [NUM_CH-1:0] ch_pend;

  // Counter advance, period apply and write validation.
  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    per_sh_d = per_sh_q;
    ps_d     = ps_q;
    err_d    = err_q;
    wrap     = ({1'b0, cnt_q} == (per_q - ONE));
    apply    = bus.run & wrap;
    per_ok   = (bus.per_val >= P_MIN) &&
               (bus.per_val <= P_MAX);
    per_acc  = bus.run & bus.per_we & per_ok;
    chk_per  = per_acc ? bus.per_val : per_sh_q;
    sel_ext  = 32'(bus.ch_sel);
    sel_ok   = (sel_ext < 32'(NUM_CH));
    pos_ok   = ({1'b0, bus.ch_rise} < chk_per) &&
               ({1'b0, bus.ch_fall} < chk_per);
    ch_acc   = bus.run & bus.ch_we & sel_ok & pos_ok;
    if (bus.run) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (apply) begin
        per_d = per_sh_q;
      end
      if (per_acc) begin
        per_sh_d = bus.per_val;
      end
      ps_d  = (cnt_d == '0);
      err_d = (bus.per_we & ~per_ok) |
              (bus.ch_we & ~(sel_ok & pos_ok));
    end
  end

  // Counter, period and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      per_q    <= P_RST;
      per_sh_q <= P_RST;
      ps_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      per_sh_q <= per_sh_d;
      ps_q     <= ps_d;
      err_q    <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_phase_gen_phase_chan #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_phase_chan (
      .clock     (clock),
      .reset     (reset),
      .en_i      (bus.run),
      .apply_i   (apply),
      .wr_i      (ch_acc &&
                  (bus.ch_sel == SEL_W'(i))),
      .rise_i    (bus.ch_rise),
      .fall_i    (bus.ch_fall),
      .inv_i     (bus.ch_inv),
      .cnt_d_i   (cnt_d),
      .per_d_i   (per_d),
      .clk_o     (ch_clk[i]),
      .pulse_o   (ch_pulse[i]),
      .pending_o (ch_pend[i])
    );
  end

  assign bus.ch_clk        = ch_clk;
  assign bus.ch_rise_pulse = ch_pulse & {NUM_CH{bus.run}};
  assign bus.phase_cnt     = cnt_q;
  assign bus.period_start  = ps_q & bus.run;
  assign bus.cfg_pending   = (per_sh_q != per_q) | (|ch_pend);
  assign bus.cfg_err       = err_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Bench for clk_phase_gen: directed scenarios plus random traffic,
// all checked each cycle against a behavioural phase model.
module tb_clk_phase_gen;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int SW  = 2;
  localparam int RP  = 4;
  localparam int PM  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  clk_phase_gen_if #(
    .NUM_CH (NCH), .CNT_W (CW), .SEL_W (SW)
  ) bus ();

  clk_phase_gen #(
    .NUM_CH (NCH), .CNT_W (CW),
    .RESET_PERIOD (RP), .SEL_W (SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int m_cnt, m_per, s_per;
  int a_r[NCH], a_f[NCH], s_r[NCH], s_f[NCH];
  bit a_i[NCH], s_i[NCH];
  logic [NCH-1:0] m_clk, m_pulse;
  bit m_ps, m_err;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Window as a modular distance from rise; unreachable rise or
  // an empty window leaves the output at its inversion level.
  function automatic bit lvl(int r, int f, bit inv, int c, int p);
    bit h;
    if (r >= p || r == f) h = 0;
    else h = ((c - r + PM) % PM) < ((f - r + PM) % PM);
    return h ^ inv;
  endfunction

  function automatic bit m_pend();
    if (s_per != m_per) return 1;
    for (int i = 0; i < NCH; i++)
      if (s_r[i] != a_r[i] || s_f[i] != a_f[i] ||
          s_i[i] != a_i[i]) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_per = RP; s_per = RP;
    for (int i = 0; i < NCH; i++) begin
      a_r[i] = 0; a_f[i] = RP / 2; a_i[i] = 0;
      s_r[i] = 0; s_f[i] = RP / 2; s_i[i] = 0;
    end
    m_clk = '0; m_pulse = '0; m_ps = 0; m_err = 0;
  endtask

  task automatic m_step();
    logic [NCH-1:0] old;
    bit wrap, pok, cok;
    int pv, lim, sel;
    old = m_clk;
    wrap = (m_cnt == m_per - 1);
    if (wrap) begin
      m_per = s_per;
      for (int i = 0; i < NCH; i++) begin
        a_r[i] = s_r[i]; a_f[i] = s_f[i]; a_i[i] = s_i[i];
      end
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
    pv  = int'(bus.per_val);
    pok = (pv >= 2 && pv <= PM);
    lim = (bus.per_we && pok) ? pv : s_per;
    sel = int'(bus.ch_sel);
    cok = sel < NCH && int'(bus.ch_rise) < lim &&
          int'(bus.ch_fall) < lim;
    m_err = (bus.per_we && !pok) || (bus.ch_we && !cok);
    if (bus.per_we && pok) s_per = pv;
    if (bus.ch_we && cok) begin
      s_r[sel] = int'(bus.ch_rise);
      s_f[sel] = int'(bus.ch_fall);
      s_i[sel] = bus.ch_inv;
    end
    for (int i = 0; i < NCH; i++)
      m_clk[i] = lvl(a_r[i], a_f[i], a_i[i], m_cnt, m_per);
    m_pulse = m_clk & ~old;
    m_ps = (m_cnt == 0);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) m_reset();
    else if (bus.run) m_step();
  end

  always @(negedge clock) begin
    chk("phase_cnt", int'(bus.phase_cnt), m_cnt);
    chk("ch_clk", int'(bus.ch_clk), int'(m_clk));
    chk("rise_pulse", int'(bus.ch_rise_pulse),
        bus.run ? int'(m_pulse) : 0);
    chk("period_start", int'(bus.period_start),
        int'(m_ps && bus.run));
    chk("cfg_pending", int'(bus.cfg_pending), int'(m_pend()));
    chk("cfg_err", int'(bus.cfg_err), int'(m_err));
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic wr_ch(int s, int r, int f, bit iv);
    bus.ch_we = 1'b1;
    bus.ch_sel = SW'(s);
    bus.ch_rise = CW'(r);
    bus.ch_fall = CW'(f);
    bus.ch_inv = iv;
    cyc();
    bus.ch_we = 1'b0;
  endtask

  task automatic wait_phase(int ph);
    for (int i = 0; i < 40; i++) begin
      if (int'(bus.phase_cnt) == ph) break;
      cyc();
    end
    chk("wait_phase", int'(bus.phase_cnt), ph);
  endtask

  initial begin
    m_reset();
    bus.run = 1'b0; bus.per_we = 1'b0; bus.per_val = '0;
    bus.ch_we = 1'b0; bus.ch_sel = '0; bus.ch_rise = '0;
    bus.ch_fall = '0; bus.ch_inv = 1'b0;
    cyc(); cyc();
    chk("rst_phase", int'(bus.phase_cnt), 0);
    chk("rst_clk", int'(bus.ch_clk), 0);
    chk("rst_pend", int'(bus.cfg_pending), 0);
    reset = 1'b0;
    bus.run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("dflt_phase", int'(bus.phase_cnt), k % 4);
      chk("dflt_clk", int'(bus.ch_clk), (k % 4 < 2) ? 15 : 0);
      chk("dflt_ps", int'(bus.period_start), int'(k % 4 == 0));
      chk("dflt_pulse", int'(bus.ch_rise_pulse),
          (k % 4 == 0 || k == 1) ? 15 : 0);
    end
    wr_ch(2, 3, 1, 0);
    chk("pend_set", int'(bus.cfg_pending), 1);
    cyc(); cyc();
    chk("pend_hold", int'(bus.cfg_pending), 1);
    cyc();
    chk("pend_clr", int'(bus.cfg_pending), 0);
    chk("ch2_ph0", int'(bus.ch_clk[2]), 1);
    cyc();
    chk("ch_ph1", int'(bus.ch_clk), 11);
    cyc(); cyc();
    chk("ch_ph3", int'(bus.ch_clk), 4);
    bus.per_we = 1'b1; bus.per_val = 5'd6;
    cyc();
    bus.per_we = 1'b0;
    chk("per_wrap_pend", int'(bus.cfg_pending), 1);
    repeat (3) cyc();
    chk("per_still4", int'(bus.phase_cnt), 3);
    cyc();
    chk("per_wrap0", int'(bus.phase_cnt), 0);
    chk("per_applied", int'(bus.cfg_pending), 0);
    repeat (5) cyc();
    chk("per6_ph5", int'(bus.phase_cnt), 5);
    cyc();
    bus.per_we = 1'b1; bus.per_val = 5'd1;
    cyc();
    bus.per_we = 1'b0;
    chk("err_per", int'(bus.cfg_err), 1);
    chk("err_per_pend", int'(bus.cfg_pending), 0);
    wr_ch(0, 7, 2, 0);
    chk("err_ch", int'(bus.cfg_err), 1);
    chk("err_ch_pend", int'(bus.cfg_pending), 0);
    cyc();
    chk("err_clr", int'(bus.cfg_err), 0);
    wait_phase(2);
    bus.run = 1'b0;
    repeat (5) begin
      cyc();
      chk("frz_phase", int'(bus.phase_cnt), 2);
      chk("frz_pulse", int'(bus.ch_rise_pulse), 0);
      chk("frz_ps", int'(bus.period_start), 0);
    end
    bus.run = 1'b1;
    cyc();
    chk("resume", int'(bus.phase_cnt), 3);
    wait_phase(1);
    wr_ch(1, 1, 3, 1);
    chk("rst_pend_set", int'(bus.cfg_pending), 1);
    reset = 1'b1;
    #1;
    chk("arst_clk", int'(bus.ch_clk), 0);
    chk("arst_phase", int'(bus.phase_cnt), 0);
    chk("arst_pend", int'(bus.cfg_pending), 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_phase", int'(bus.phase_cnt), 1);
    chk("post_rst_clk", int'(bus.ch_clk), 15);
    chk("post_rst_pend", int'(bus.cfg_pending), 0);
    repeat (3000) begin
      bus.run     = ($urandom_range(0, 7) != 0);
      bus.per_we  = ($urandom_range(0, 15) == 0);
      bus.per_val = 5'($urandom_range(0, 31));
      bus.ch_we   = ($urandom_range(0, 3) == 0);
      bus.ch_sel  = 2'($urandom_range(0, 3));
      bus.ch_rise = 4'($urandom_range(0, 15));
      bus.ch_fall = 4'($urandom_range(0, 15));
      bus.ch_inv  = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
